// File: rtl/run_monitor.sv
// -----------------------------------------------------------------------------
// run_monitor
//
// Watches the PROCESSOR core's zero flag and measures each run in clock cycles.
// A run ends in DONE when zero has been sampled high on STABLE_CYCLES
// consecutive RUN edges. It ends in TIMEOUT when the cycle budget MAX_CYCLES is
// spent. If both conditions occur on the same edge, DONE wins.
//
// Ports
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   launches a run from IDLE, DONE or TIMEOUT (ignored in RUN)
//   zero         in   zero flag from the core, same clock domain
//   busy         out  registered, high while running
//   done         out  registered, high after a halt was detected
//   timeout      out  registered, high after the cycle budget ran out
//   cycle_count  out  RUN edges in the current or last run
//   zero_count   out  rising edges of zero seen in the run (saturating)
// -----------------------------------------------------------------------------
module run_monitor #(
    parameter int MAX_CYCLES    = 12,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             zero,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] zero_count
);

    localparam int SW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0]    STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CYC_MAX    = CNT_W'(MAX_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0] zcnt_q, zcnt_d;
    logic [SW-1:0]    stable_q, stable_d;
    logic             zero_q, zero_d;
    logic             busy_q, done_q, timeout_q;

    // One bit wider than the stable counter so the compare never wraps.
    logic [SW:0]      stable_inc;
    logic [CNT_W-1:0] cyc_inc;
    logic             halt, budget_out;

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        zcnt_d     = zcnt_q;
        stable_d   = stable_q;
        zero_d     = zero_q;
        stable_inc = {1'b0, stable_q} + 1'b1;
        cyc_inc    = cyc_q + 1'b1;
        halt       = 1'b0;
        budget_out = 1'b0;

        unique case (state_q)
            S_RUN: begin
                cyc_d  = cyc_inc;
                zero_d = zero;
                if (zero && !zero_q && (zcnt_q != '1)) begin
                    zcnt_d = zcnt_q + 1'b1;
                end
                if (!zero) begin
                    stable_d = '0;
                end else if (stable_q != STABLE_MAX) begin
                    stable_d = stable_inc[SW-1:0];
                end
                halt       = zero && (stable_inc == {1'b0, STABLE_MAX});
                budget_out = (cyc_inc == CYC_MAX);
                // Halt is checked first so it wins a tie with the budget.
                if (halt) begin
                    state_d = S_DONE;
                end else if (budget_out) begin
                    state_d = S_TIMEOUT;
                end
            end
            default: begin
                // IDLE, DONE and TIMEOUT all relaunch on start; counters hold otherwise.
                if (start) begin
                    state_d  = S_RUN;
                    cyc_d    = '0;
                    zcnt_d   = '0;
                    stable_d = '0;
                    zero_d   = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cyc_q     <= '0;
            zcnt_q    <= '0;
            stable_q  <= '0;
            zero_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            zcnt_q    <= zcnt_d;
            stable_q  <= stable_d;
            zero_q    <= zero_d;
            // Status flags are registered copies of the next state, so they are one-hot or idle.
            busy_q    <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
            timeout_q <= (state_d == S_TIMEOUT);
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cyc_q;
    assign zero_count  = zcnt_q;

endmodule

// File: tb/tb_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_run_monitor
//
// Self-checking bench for run_monitor. Each run is described by a zero-flag
// pattern. A behavioural model predicts the outcome from that pattern: whether
// the run ends in DONE, the final cycle count and the number of zero rising
// edges. Directed patterns and random patterns are both applied.
// -----------------------------------------------------------------------------
module tb_run_monitor;

    localparam int MAXC = 12;
    localparam int STAB = 4;
    localparam int CW   = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          zero;
    logic          busy, done, timeout;
    logic [CW-1:0] cycle_count, zero_count;

    int total = 0;
    int bad   = 0;
    bit zpat [0:15];

    run_monitor #(
        .MAX_CYCLES   (MAXC),
        .STABLE_CYCLES(STAB),
        .CNT_W        (CW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .zero       (zero),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .cycle_count(cycle_count),
        .zero_count (zero_count)
    );

    always #20 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_pat(input logic [15:0] v);
        for (int i = 0; i < 16; i++) zpat[i] = v[i];
    endtask

    // Outcome from the rules: the run halts at the first edge k at or before the
    // budget whose last STAB samples are all high; otherwise it ends at MAXC.
    // Rising edges count samples that are high after a low (or after run entry).
    function automatic void model(output bit d, output int e, output int zc);
        bit all1;
        d = 1'b0;
        e = MAXC;
        for (int k = STAB; k <= MAXC; k++) begin
            if (!d) begin
                all1 = 1'b1;
                for (int j = k - STAB; j < k; j++) all1 &= zpat[j];
                if (all1) begin
                    d = 1'b1;
                    e = k;
                end
            end
        end
        zc = 0;
        for (int k = 0; k < e; k++)
            if (zpat[k] && (k == 0 || !zpat[k-1])) zc++;
    endfunction

    task automatic do_run(input string name, input int poke_at);
        bit exp_done;
        int exp_end, exp_zc, k;
        model(exp_done, exp_end, exp_zc);
        start = 1'b1;
        zero  = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        check({name, ":launch_busy"}, busy, 1);
        check({name, ":launch_cyc"}, cycle_count, 0);
        check({name, ":launch_zc"}, zero_count, 0);
        zero = zpat[0];
        k = 0;
        while (busy && k < MAXC + 2) begin
            // A start pulse during RUN must leave the count untouched.
            start = (k == poke_at);
            @(posedge clock); #1;
            k++;
            check({name, ":onehot"}, $countones({busy, done, timeout}) <= 1, 1);
            check({name, ":cyc_step"}, cycle_count, k);
            zero = zpat[k];
        end
        start = 1'b0;
        check({name, ":ended"}, busy, 0);
        check({name, ":done"}, done, exp_done);
        check({name, ":timeout"}, timeout, !exp_done);
        check({name, ":cyc_final"}, cycle_count, exp_end);
        check({name, ":zc_final"}, zero_count, exp_zc);
        zero = $urandom_range(0, 1);
        @(posedge clock); #1;
        check({name, ":hold_done"}, done, exp_done);
        check({name, ":hold_cyc"}, cycle_count, exp_end);
        check({name, ":hold_zc"}, zero_count, exp_zc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held for 50 ns while start and zero wiggle.
        reset = 1'b0;
        start = 1'b1;
        zero  = 1'b1;
        #25;
        check("rst:busy", busy, 0);
        check("rst:done", done, 0);
        check("rst:timeout", timeout, 0);
        check("rst:cyc", cycle_count, 0);
        check("rst:zc", zero_count, 0);
        start = 1'b0;
        zero  = 1'b0;
        #10 start = 1'b1;
        #10 start = 1'b0;
        #5 reset = 1'b1;
        @(posedge clock); #1;
        check("post_rst:busy", busy, 0);
        check("post_rst:done", done, 0);
        check("post_rst:timeout", timeout, 0);

        set_pat(16'h0000); do_run("timeout", -1);
        set_pat(16'hFFFC); do_run("halt", -1);
        set_pat(16'hFFF7); do_run("glitch1", -1);
        set_pat(16'h5555); do_run("glitch2", 3);
        set_pat(16'hFF00); do_run("simul", 5);

        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 16; i++) zpat[i] = ($urandom_range(0, 3) != 0);
            do_run("rand", $urandom_range(0, 14));
        end

        // Reset in the middle of a run clears everything before the next edge.
        set_pat(16'h0000);
        start = 1'b1;
        zero  = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #5 reset = 1'b0;
        #1;
        check("midrst:busy", busy, 0);
        check("midrst:done", done, 0);
        check("midrst:timeout", timeout, 0);
        check("midrst:cyc", cycle_count, 0);
        check("midrst:zc", zero_count, 0);
        #4 reset = 1'b1;
        @(posedge clock); #1;
        check("midrst:stay_idle", busy, 0);
        check("midrst:cyc_idle", cycle_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
